// File: rtl/vga_fb_if.sv
// vga_fb_if: video/CPU request ports and framebuffer RAM bus around the arbiter
interface vga_fb_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_gnt;
   logic [DATA_W-1:0] vid_rdata;
   logic              vid_rvalid;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              starve_flag;
   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  vid_gnt, vid_rdata, vid_rvalid, cpu_ack, cpu_rdata, cpu_rvalid,
             mem_en, mem_we, mem_addr, mem_wdata, starve_flag
   );
   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output vid_gnt, vid_rdata, vid_rvalid, cpu_ack, cpu_rdata, cpu_rvalid,
             mem_en, mem_we, mem_addr, mem_wdata, starve_flag
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: fixed-priority video/CPU framebuffer arbiter with CPU starvation override
module vga_fb_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 800
) (
   input logic     clk,
   input logic     rst,
   vga_fb_if.slave bus
);
   typedef enum logic [1:0] {IDLE, VID, CPU} owner_t;
   localparam int CW = $clog2(STARVE_MAX + 1);
   owner_t            owner, owner_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic              cpu_elig, forced, flag_q, we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, vid_hold, cpu_hold;
   logic [RD_LAT-1:0] vtag, ctag;
   always_comb begin
      cpu_elig  = bus.cpu_req & ~bus.cpu_ack;
      forced    = cpu_elig && cnt == CW'(STARVE_MAX);
      owner_nxt = forced ? CPU : bus.vid_req ? VID : cpu_elig ? CPU : IDLE;
      cnt_nxt   = (!bus.cpu_req || owner_nxt == CPU) ? '0 :
                  (cpu_elig && cnt != CW'(STARVE_MAX)) ? cnt + 1'b1 : cnt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         owner    <= IDLE;
         cnt      <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         flag_q   <= 1'b0;
         vtag     <= '0;
         ctag     <= '0;
         vid_hold <= '0;
         cpu_hold <= '0;
      end else begin
         owner    <= owner_nxt;
         cnt      <= cnt_nxt;
         we_q     <= owner_nxt == CPU && bus.cpu_we;
         addr_q   <= owner_nxt == VID ? bus.vid_addr : owner_nxt == CPU ? bus.cpu_addr : '0;
         wdata_q  <= (owner_nxt == CPU && bus.cpu_we) ? bus.cpu_wdata : '0;
         flag_q   <= flag_q | forced;
         vtag     <= RD_LAT'({vtag, owner == VID});
         ctag     <= RD_LAT'({ctag, owner == CPU && !we_q});
         vid_hold <= bus.vid_rvalid ? bus.mem_rdata : vid_hold;
         cpu_hold <= bus.cpu_rvalid ? bus.mem_rdata : cpu_hold;
      end
   end
   assign bus.vid_gnt     = owner == VID;
   assign bus.cpu_ack     = owner == CPU;
   assign bus.mem_en      = owner != IDLE;
   assign bus.mem_we      = we_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.starve_flag = flag_q;
   assign bus.vid_rvalid  = vtag[RD_LAT-1];
   assign bus.cpu_rvalid  = ctag[RD_LAT-1];
   assign bus.vid_rdata   = bus.vid_rvalid ? bus.mem_rdata : vid_hold;
   assign bus.cpu_rdata   = bus.cpu_rvalid ? bus.mem_rdata : cpu_hold;
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Single-port framebuffer access arbiter between the VGA scanout fetch unit (video port) and a CPU/draw-engine port. The video port gets fixed priority. A starvation counter forces one CPU grant when the CPU has waited too long. The block drives the synchronous single-port framebuffer RAM and routes read data back to its owner. It sits between VGA_Controller's pixel fetch logic and the framebuffer RAM.

Parameters:
ADDR_W, 16, framebuffer address width
DATA_W, 8, pixel/data width
RD_LAT, 1, RAM read latency in cycles from mem_en; legal values 1 or 2
STARVE_MAX, 800, consecutive cycles of CPU pending without grant that force a CPU grant

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
vid_req  in  1  video access request; held with vid_addr until vid_gnt
vid_addr  in  ADDR_W  video read address
vid_gnt  out  1  one-cycle pulse: video access issued to RAM this cycle
vid_rdata  out  DATA_W  video read data
vid_rvalid  out  1  vid_rdata valid
cpu_req  in  1  CPU request; held with cpu_we/addr/wdata stable until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle pulse: CPU access issued to RAM this cycle
cpu_rdata  out  DATA_W  CPU read data
cpu_rvalid  out  1  cpu_rdata valid (reads only)
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data
starve_flag  out  1  sticky: a forced CPU grant has occurred; cleared only by rst

Behaviour:
- Reset (rst high at posedge): all outputs 0; owner = IDLE; starvation counter = 0; return-tag pipeline cleared. Reset mid-transaction drops in-flight reads: no rvalid is ever produced for them.
- Arbitration at each posedge uses sampled requests. The winner's access is driven on registered mem_* outputs in the following cycle, together with vid_gnt or cpu_ack in that same cycle.
- Owner FSM, re-evaluated every cycle:
  - IDLE: no eligible request; mem_en = 0.
  - VID: video wins.
  - CPU: CPU wins.
- Priority order:
  1. Forced CPU, when counter == STARVE_MAX and CPU eligible.
  2. Video, when vid_req = 1.
  3. CPU, when eligible.
  4. IDLE.
- CPU eligible = cpu_req & ~cpu_ack. The cycle showing cpu_ack blocks a re-grant of the same held request, so CPU throughput is at most 1 access per 2 cycles. Video may win every cycle (back-to-back streaming).
- Starvation counter:
  - Increments each cycle CPU is eligible and not granted; saturates at STARVE_MAX.
  - Resets to 0 on a CPU grant or when cpu_req = 0.
  - A forced grant sets starve_flag. That cycle video is not granted; the video port holds its request.
- Write: mem_we = 1, mem_wdata = cpu_wdata; no rvalid is produced.
- Read return:
  - A tag shift register of depth RD_LAT records the owner (none/vid/cpu) of each issued read.
  - mem_rdata is passed to vid_rdata or cpu_rdata with the matching rvalid exactly RD_LAT cycles after the mem_en cycle.
  - Data outputs hold their last value when not valid.
- Simultaneous vid_req and cpu_req below the starvation limit: video wins and the counter increments.
- Address wrap: none. Addresses pass through unchanged.

Test Plan:
1. Reset: rst high for 2 cycles with both requests high -> all outputs 0, starve_flag 0; first mem_en appears 1 cycle after rst falls, with vid_gnt = 1.
2. CPU write then read, video idle: cpu_we = 1, addr 0x0010, data 0xA5 -> cpu_ack 1 cycle later with mem_we = 1, mem_addr 0x0010. Then a read of 0x0010 -> cpu_rvalid = 1 with cpu_rdata 0xA5 exactly RD_LAT cycles after its mem_en (run with RD_LAT = 1 and RD_LAT = 2).
3. Contention: vid_req held high while CPU requests addr 0x0020 -> vid_gnt every cycle for 800 cycles, then exactly one cpu_ack cycle with vid_gnt = 0 and starve_flag = 1; video grants resume the next cycle.
4. Release before starving: video streams for 100 cycles, then vid_req falls -> cpu_ack in the next cycle, starve_flag stays 0, counter returns to 0.
5. Back-to-back CPU: cpu_req held high for 6 cycles with video idle -> cpu_ack pulses on alternating cycles (3 pulses); no duplicate grant in the cycle after any ack.
6. Reset mid-read: assert rst in the cycle after a video read mem_en with RD_LAT = 2 -> vid_rvalid never asserts for that read; all outputs are 0 the cycle after rst.
